// File: rtl/spi_slave_engine.sv
// spi_slave_engine
//   Bit-level SPI slave front end running entirely in the clk domain.
//   The SCLK/CS_n/MOSI pins are synchronised and edge-detected. MOSI words
//   are deserialised into the RX FIFO write port, and words popped from the
//   TX FIFO (registered read port) are serialised MSB first onto MISO.
//
// Parameters
//   WIDTH : word length in bits (>= 2), equal to the FIFO width
//   CPOL  : SCLK idle level
//   CPHA  : 0 = sample on leading edge, 1 = sample on trailing edge
//
// Ports
//   clk, rst            : system clock, synchronous active-high reset
//   sclk, cs_n, mosi    : asynchronous SPI pins
//   miso, miso_oe       : SPI data out and its tristate enable
//   rxData, rxWrite     : received word and write pulse to the RX FIFO
//   rxFull              : RX FIFO full
//   txData, txRead      : TX FIFO read data and read pulse
//   txEmpty             : TX FIFO empty
//   clrFlags            : clears the sticky overrun/underrun flags
//   overrun, underrun   : sticky error flags
//   busy                : engine is not idle
module spi_slave_engine #(
   parameter int unsigned WIDTH = 8,
   parameter bit          CPOL  = 1'b0,
   parameter bit          CPHA  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   output logic [WIDTH-1:0] rxData,
   output logic             rxWrite,
   input  logic             rxFull,
   input  logic [WIDTH-1:0] txData,
   output logic             txRead,
   input  logic             txEmpty,
   input  logic             clrFlags,
   output logic             overrun,
   output logic             underrun,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      ACTIVE
   } state_t;

   state_t           state;

   logic             sclk_s1, sclk_s2, sclk_h;
   logic             cs_s1, cs_s2, cs_h;
   logic             mosi_s1, mosi_s2;

   logic [WIDTH-1:0] txShift;
   logic [WIDTH-1:0] txNext;
   logic [WIDTH-2:0] rxShift;
   logic [CW-1:0]    bitCnt;
   logic             txPending;
   logic             fetch_cnt;
   // High in the cycle the TX FIFO read data belongs to a fetch.
   logic             cap;

   logic             sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic             sample_edge, shift_edge, word_done;
   logic [WIDTH-1:0] rx_word;
   logic [WIDTH-1:0] fetch_word;

   // Pin synchronisers plus history flops for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_s1 <= CPOL;
         sclk_s2 <= CPOL;
         sclk_h  <= CPOL;
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_h    <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_h  <= sclk_s2;
         cs_s1   <= cs_n;
         cs_s2   <= cs_s1;
         cs_h    <= cs_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sclk_rise   = sclk_s2 & ~sclk_h;
   assign sclk_fall   = ~sclk_s2 & sclk_h;
   assign cs_fall     = ~cs_s2 & cs_h;
   assign cs_rise     = cs_s2 & ~cs_h;
   assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
   assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;
   assign rx_word     = {rxShift, mosi_s2};
   assign word_done   = (bitCnt == CW'(WIDTH - 1));
   // Result of the fetch started on CS fall, as seen on FETCH exit.
   assign fetch_word  = cap ? txData : txNext;
   assign miso        = txShift[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         miso_oe   <= 1'b0;
         busy      <= 1'b0;
         rxWrite   <= 1'b0;
         txRead    <= 1'b0;
         overrun   <= 1'b0;
         underrun  <= 1'b0;
         rxData    <= '0;
         rxShift   <= '0;
         txShift   <= '0;
         txNext    <= '0;
         bitCnt    <= '0;
         txPending <= 1'b0;
         fetch_cnt <= 1'b0;
         cap       <= 1'b0;
      end else begin
         rxWrite <= 1'b0;
         txRead  <= 1'b0;
         // A CS rise right after the read pulse drops the returned word.
         cap     <= txRead & ~cs_rise;
         if (cap) begin
            txNext <= txData;
         end

         // Clear first so a same-cycle set below takes precedence.
         if (clrFlags) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
         end

         if (cs_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            miso_oe   <= 1'b0;
            bitCnt    <= '0;
            rxShift   <= '0;
            txPending <= 1'b0;
            fetch_cnt <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state     <= FETCH;
                     busy      <= 1'b1;
                     miso_oe   <= 1'b1;
                     fetch_cnt <= 1'b0;
                     if (!txEmpty) begin
                        txRead <= 1'b1;
                     end else begin
                        txNext   <= '0;
                        underrun <= 1'b1;
                     end
                  end
               end

               FETCH: begin
                  fetch_cnt <= 1'b1;
                  if (fetch_cnt) begin
                     state <= ACTIVE;
                     if (CPHA == 1'b0) begin
                        txShift   <= fetch_word;
                        txPending <= 1'b0;
                     end else begin
                        txPending <= 1'b1;
                     end
                  end
               end

               ACTIVE: begin
                  if (shift_edge) begin
                     if (txPending) begin
                        txShift   <= txNext;
                        txPending <= 1'b0;
                     end else begin
                        txShift <= {txShift[WIDTH-2:0], 1'b0};
                     end
                  end else if (sample_edge) begin
                     rxShift <= rx_word[WIDTH-2:0];
                     if (word_done) begin
                        bitCnt    <= '0;
                        txPending <= 1'b1;
                        if (!rxFull) begin
                           rxWrite <= 1'b1;
                           rxData  <= rx_word;
                        end else begin
                           overrun <= 1'b1;
                        end
                        // Eager fetch of the next TX word.
                        if (!txEmpty) begin
                           txRead <= 1'b1;
                        end else begin
                           txNext   <= '0;
                           underrun <= 1'b1;
                        end
                     end else begin
                        bitCnt <= bitCnt + 1'b1;
                     end
                  end
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
